// File: rtl/alu_pkg.sv
// Shared ALU opcode and sequencer state definitions.
// Imported by the ALU, the command sequencer and its bench.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        SUB  = 2'd1,
        MUL  = 2'd2,
        NAND = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } seq_state_e;

    function automatic logic is_mul(input logic [1:0] opcode);
        return opcode == MUL;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Show-ahead synchronous FIFO holding {opcode, op1, op2} commands.
// Push is ignored when full and pop is ignored when empty.
module alu_cmd_fifo #(
    parameter int WIDTH        = 32,
    parameter int OPCODE_WIDTH = 2,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [OPCODE_WIDTH-1:0] push_opcode,
    input  logic [WIDTH-1:0]        push_op1,
    input  logic [WIDTH-1:0]        push_op2,
    input  logic                    pop,
    output logic [OPCODE_WIDTH-1:0] head_opcode,
    output logic [WIDTH-1:0]        head_op1,
    output logic [WIDTH-1:0]        head_op2,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [OPCODE_WIDTH-1:0] mem_opcode [DEPTH];
    logic [WIDTH-1:0]        mem_op1    [DEPTH];
    logic [WIDTH-1:0]        mem_op2    [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_opcode = mem_opcode[rd_ptr];
    assign head_op1    = mem_op1[rd_ptr];
    assign head_op2    = mem_op2[rd_ptr];

    // Power-of-2 depth lets the pointers wrap on natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_opcode[wr_ptr] <= push_opcode;
            mem_op1[wr_ptr]    <= push_op1;
            mem_op2[wr_ptr]    <= push_op2;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational ALU: buffers commands, drives one at a time,
// waits the per-opcode settle time and returns the registered result.
//
//   state | meaning
//   IDLE  | nothing in flight; pops the FIFO head as soon as one is present
//   EXEC  | operands on the ALU; cnt counts down the remaining settle cycles
//   HOLD  | result registered, rsp_valid high until the consumer takes it
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int OPCODE_WIDTH = 2,
    parameter int DEPTH        = 4,
    parameter int MUL_CYCLES   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
    input  logic [WIDTH-1:0]        cmd_op1,
    input  logic [WIDTH-1:0]        cmd_op2,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic [WIDTH-1:0]        alu_op1,
    output logic [WIDTH-1:0]        alu_op2,
    input  logic [WIDTH-1:0]        alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_result,
    output logic [OPCODE_WIDTH-1:0] rsp_opcode,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    busy
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    seq_state_e              state;
    logic [CNT_W-1:0]        cnt;
    logic [OPCODE_WIDTH-1:0] head_opcode;
    logic [WIDTH-1:0]        head_op1;
    logic [WIDTH-1:0]        head_op2;
    logic                    full;
    logic                    empty;
    logic                    pop;

    assign cmd_ready = !full;
    assign busy      = (state != IDLE) || !empty;
    // HOLD hands straight over to the next command on the handshake edge.
    assign pop       = !empty && ((state == IDLE) || ((state == HOLD) && rsp_ready));

    alu_cmd_fifo #(
        .WIDTH        (WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (cmd_valid),
        .push_opcode (cmd_opcode),
        .push_op1    (cmd_op1),
        .push_op2    (cmd_op2),
        .pop         (pop),
        .head_opcode (head_opcode),
        .head_op1    (head_op1),
        .head_op2    (head_op2),
        .full        (full),
        .empty       (empty),
        .count       (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_opcode <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) state <= EXEC;
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_opcode <= alu_opcode;
                        rsp_valid  <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                alu_opcode <= head_opcode;
                alu_op1    <= head_op1;
                alu_op2    <= head_op2;
                cnt        <= is_mul(2'(head_opcode)) ? MUL_LOAD : '0;
            end
        end
    end

endmodule
